// File: rtl/nibble_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_sub
// Brief    : Serial a - b - bin subtractor, one 4-bit CLA nibble per clock.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_sub #(
    parameter int NNIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NNIB-1:0] a,
    input  logic [4*NNIB-1:0] b,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [4*NNIB-1:0] diff,
    output logic              bout,
    output logic              zero,
    output logic              ovf
);

    localparam int W  = 4 * NNIB;
    localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_work;
    logic [W-1:0]  w_work_next;
    logic [3:0]    w_an;
    logic [3:0]    w_bn;
    logic [3:0]    w_g;
    logic [3:0]    w_p;
    logic [3:0]    w_c;
    logic          w_cout;
    logic [3:0]    w_sum;
    logic          w_accept;
    logic          w_last;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(NNIB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Select the operand nibbles addressed by the counter.
    always_comb begin
        w_an = 4'h0;
        w_bn = 4'h0;
        for (int k = 0; k < NNIB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_an = r_a[4*k +: 4];
                w_bn = r_b[4*k +: 4];
            end
        end
    end

    // a + ~b + ~borrow with lookahead carries; borrow-out is the inverted carry.
    assign w_g    = w_an & ~w_bn;
    assign w_p    = w_an ^ ~w_bn;
    assign w_c[0] = ~r_borrow;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum  = w_p ^ w_c;

    always_comb begin
        w_work_next = r_work;
        for (int k = 0; k < NNIB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_work_next[4*k +: 4] = w_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_work   <= '0;
        end else if (r_state == S_RUN) begin
            r_work   <= w_work_next;
            r_borrow <= ~w_cout;
            r_cnt    <= r_cnt + CW'(1);
            // Results are published only as the last nibble completes.
            if (w_last) begin
                diff <= w_work_next;
                bout <= ~w_cout;
                zero <= (w_work_next == '0);
                ovf  <= (r_a[W-1] != r_b[W-1]) && (w_work_next[W-1] != r_a[W-1]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_sub
// Brief    : Directed, table-driven bench for nibble_serial_sub (NNIB=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    nibble_serial_sub #(.NNIB(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
    endtask

    // Returns at the negedge where done is seen (or the bound expires).
    task automatic wait_done(output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        logic [15:0] dsave;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_flags", {29'd0, bout, zero, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            launch(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(lat, bcnt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd4);
            chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].d));
            chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bo));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(diff), 32'(vecs[i].d));
        end

        // Start pulsed during RUN must be ignored; results hold while busy.
        dsave = diff;
        @(negedge clk);
        launch(16'h00F0, 16'h000F, 1'b0);
        @(negedge clk);
        start = 1'b0;
        launch(16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_diff_hold", 32'(diff), 32'(dsave));
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                ndone++;
                chk("ign_diff", 32'(diff), 32'h00E1);
            end
            @(negedge clk);
        end
        chk("ign_done_count", 32'(ndone), 32'd1);

        // Reset mid-RUN abandons the operation; restart immediately after.
        launch(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_done", 32'(done), 32'd0);
        chk("rstrun_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        launch(16'h0010, 16'h0001, 1'b0);
        wait_done(lat, bcnt);
        chk("post_rst_latency", 32'(lat), 32'd5);
        chk("post_rst_diff", 32'(diff), 32'h000F);

        // Back-to-back: new start accepted in DONE, no idle gap.
        @(negedge clk);
        launch(16'h1234, 16'h0234, 1'b0);
        wait_done(lat, bcnt);
        chk("b2b_first_diff", 32'(diff), 32'h1000);
        launch(16'h0010, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_gap_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", 32'(lat), 32'd5);
        chk("b2b_second_diff", 32'(diff), 32'h000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
